controleur_partie: RTL and testbench

CONTROLEUR_PARTIE -- requirements
Module: controleur_partie

---
 rtl/trois_briques_pkg.sv | 24 ++
 rtl/controleur_partie_diviseur_chute.sv | 43 ++++
 rtl/controleur_partie.sv | 111 +++++++++++
 tb/tb_controleur_partie.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/trois_briques_pkg.sv
// rtl/trois_briques_pkg.sv - shared state codes, widths and defaults for the three-stack game
package trois_briques_pkg;

  localparam int HAUTEUR_W       = 3;
  localparam int HAUTEUR_MAX_DEF = 7;
  localparam int TICKS_NIV0_DEF  = 8;

  typedef enum logic [2:0] {
    ATTENTE = 3'd0,
    CHUTE   = 3'd1,
    POSE    = 3'd2,
    EFFACE  = 3'd3,
    REPRISE = 3'd4,
    PERDU   = 3'd5
  } etat_t;

  // Gravity period shrinks by one tick per level and never drops below one tick.
  function automatic logic [3:0] periode_de(input logic [2:0] niv, input int ticks);
    int p;
    p = ticks - int'(niv);
    return (p < 1) ? 4'd1 : 4'(p);
  endfunction

endpackage

// File: rtl/controleur_partie_diviseur_chute.sv
// rtl/controleur_partie_diviseur_chute.sv - base-tick divider producing the registered gravity pulse
module diviseur_chute (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       clear,
  input  logic [3:0] periode,
  output logic       pulse
);

  logic [3:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;

  // A tick arriving while the previous pulse is still high is dropped, so pulses never run back to back.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (run && tick && !pulse_q) begin
      if (cnt_q >= periode - 4'd1) begin
        cnt_d   = 4'd0;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/controleur_partie.sv
// rtl/controleur_partie.sv - game sequencing FSM; level acceleration under CONTROLEUR_ACCELERATION_EN
module controleur_partie
  import trois_briques_pkg::*;
#(
  parameter int HAUTEUR_MAX        = HAUTEUR_MAX_DEF,
  parameter int TICKS_NIV0         = TICKS_NIV0_DEF,
  parameter int ALIGNES_PAR_NIVEAU = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tombeeBrique,
  input  logic                 plusG,
  input  logic                 plusC,
  input  logic                 plusD,
  input  logic [HAUTEUR_W-1:0] hauteurG,
  input  logic [HAUTEUR_W-1:0] hauteurC,
  input  logic [HAUTEUR_W-1:0] hauteurD,
  output logic                 tickChute,
  output logic                 moins,
  output logic                 aligne,
  output logic                 perdu,
  output logic [2:0]           etat,
  output logic [2:0]           niveau
);

  localparam logic [HAUTEUR_W-1:0] H_MAX = HAUTEUR_W'(HAUTEUR_MAX);

  etat_t      state_q, state_d;
  logic       efface_q, perdu_q;
  logic [3:0] periode;
  logic       atterrit, trop_haut, rangee_pleine;

  assign atterrit      = plusG | plusC | plusD;
  assign trop_haut     = (hauteurG >= H_MAX) || (hauteurC >= H_MAX) || (hauteurD >= H_MAX);
  assign rangee_pleine = (hauteurG != '0) && (hauteurC != '0) && (hauteurD != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ATTENTE: if (enable) state_d = CHUTE;
      CHUTE:   if (atterrit) state_d = POSE;
      POSE: begin
        if (trop_haut)          state_d = PERDU;
        else if (rangee_pleine) state_d = EFFACE;
        else                    state_d = CHUTE;
      end
      EFFACE:  state_d = REPRISE;
      REPRISE: state_d = POSE;
      PERDU:   state_d = PERDU;
      default: state_d = ATTENTE;
    endcase
  end

  // Pulse flags are registered from the next state so they line up with the visible etat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ATTENTE;
      efface_q <= 1'b0;
      perdu_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      efface_q <= (state_d == EFFACE);
      perdu_q  <= (state_d == PERDU);
    end
  end

`ifdef CONTROLEUR_ACCELERATION_EN
  localparam logic [7:0] RANGS_FIN = 8'(ALIGNES_PAR_NIVEAU - 1);
  logic [7:0] rangs_q;
  logic [2:0] niveau_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rangs_q  <= 8'd0;
      niveau_q <= 3'd0;
    end else if (state_q == EFFACE) begin
      if (rangs_q >= RANGS_FIN) begin
        rangs_q <= 8'd0;
        if (niveau_q != 3'd7) niveau_q <= niveau_q + 3'd1;
      end else begin
        rangs_q <= rangs_q + 8'd1;
      end
    end
  end

  assign periode = periode_de(niveau_q, TICKS_NIV0);
  assign niveau  = niveau_q;
`else
  logic unused_alignes;
  assign unused_alignes = (ALIGNES_PAR_NIVEAU != 0);
  assign periode        = 4'(TICKS_NIV0);
  assign niveau         = 3'd0;
`endif

  diviseur_chute u_diviseur (
    .clk     (clk),
    .reset   (reset),
    .tick    (tombeeBrique),
    .run     ((state_q == CHUTE) && enable),
    .clear   ((state_q == CHUTE) && atterrit),
    .periode (periode),
    .pulse   (tickChute)
  );

  assign moins  = efface_q;
  assign aligne = efface_q;
  assign perdu  = perdu_q;
  assign etat   = state_q;

endmodule

// File: tb/tb_controleur_partie.sv
// tb/tb_controleur_partie.sv - directed self-checking bench for controleur_partie
module tb_controleur_partie;

  logic       clk = 1'b0;
  logic       reset, enable, tombeeBrique, plusG, plusC, plusD;
  logic [2:0] hauteurG, hauteurC, hauteurD;
  logic       tickChute, moins, aligne, perdu;
  logic [2:0] etat, niveau;

  int n_err = 0;
  int n_chk = 0;

  controleur_partie dut (
    .clk(clk), .reset(reset), .enable(enable), .tombeeBrique(tombeeBrique),
    .plusG(plusG), .plusC(plusC), .plusD(plusD),
    .hauteurG(hauteurG), .hauteurC(hauteurC), .hauteurD(hauteurD),
    .tickChute(tickChute), .moins(moins), .aligne(aligne), .perdu(perdu),
    .etat(etat), .niveau(niveau)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One base tick then three idle cycles; tickChute is read right after the tick edge.
  task automatic tick_chk(input string tag, input logic attendu);
    tombeeBrique = 1'b1;
    cyc();
    tombeeBrique = 1'b0;
    chk(tag, {7'd0, tickChute}, {7'd0, attendu});
    repeat (3) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tombeeBrique = 1'b1;
      cyc();
      tombeeBrique = 1'b0;
      cyc();
    end
  endtask

  task automatic effacer(input string tag);
    hauteurG = 3'd0; hauteurC = 3'd1; hauteurD = 3'd1;
    plusG = 1'b1;
    cyc();
    plusG = 1'b0;
    hauteurG = 3'd1;
    cyc();
    hauteurG = 3'd0; hauteurC = 3'd0; hauteurD = 3'd0;
    repeat (3) cyc();
    chk(tag, {5'd0, etat}, 8'd1);
  endtask

  int per;

  initial begin
    reset = 1'b1; enable = 1'b0; tombeeBrique = 1'b0;
    plusG = 1'b0; plusC = 1'b0; plusD = 1'b0;
    hauteurG = 3'd0; hauteurC = 3'd0; hauteurD = 3'd0;
    repeat (2) cyc();
    chk("rst_etat", {5'd0, etat}, 8'd0);
    chk("rst_tick", {7'd0, tickChute}, 8'd0);
    chk("rst_moins", {6'd0, moins, aligne}, 8'd0);
    chk("rst_perdu", {7'd0, perdu}, 8'd0);
    chk("rst_niveau", {5'd0, niveau}, 8'd0);
    reset = 1'b0;

    plusG = 1'b1;
    cyc();
    plusG = 1'b0;
    chk("attente_ignore_plus", {5'd0, etat}, 8'd0);
    enable = 1'b1;
    cyc();
    chk("attente_to_chute", {5'd0, etat}, 8'd1);

    for (int k = 1; k <= 16; k++) tick_chk("gravite_p8", (k % 8) == 0);
    chk("niveau0", {5'd0, niveau}, 8'd0);
    chk("perdu0", {7'd0, perdu}, 8'd0);

    ticks(5);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) tick_chk("pause_no_tick", 1'b0);
    chk("pause_etat", {5'd0, etat}, 8'd1);
    enable = 1'b1;
    tick_chk("reprise_t6", 1'b0);
    tick_chk("reprise_t7", 1'b0);
    tick_chk("reprise_t8", 1'b1);

    ticks(7);
    plusD = 1'b1; tombeeBrique = 1'b1; hauteurD = 3'd1;
    cyc();
    plusD = 1'b0; tombeeBrique = 1'b0;
    chk("collision_tick", {7'd0, tickChute}, 8'd0);
    chk("collision_pose", {5'd0, etat}, 8'd2);
    cyc();
    chk("pose_to_chute", {5'd0, etat}, 8'd1);
    hauteurD = 3'd0;
    ticks(7);
    tick_chk("div_cleared_t8", 1'b1);

    hauteurG = 3'd0; hauteurC = 3'd1; hauteurD = 3'd1;
    plusG = 1'b1;
    cyc();
    plusG = 1'b0;
    chk("eff_pose", {5'd0, etat}, 8'd2);
    chk("eff_pose_moins", {6'd0, moins, aligne}, 8'd0);
    hauteurG = 3'd1;
    cyc();
    chk("eff_etat", {5'd0, etat}, 8'd3);
    chk("eff_pulses", {6'd0, moins, aligne}, 8'd3);
    hauteurG = 3'd0; hauteurC = 3'd0; hauteurD = 3'd0;
    cyc();
    chk("reprise_etat", {5'd0, etat}, 8'd4);
    chk("reprise_pulses", {6'd0, moins, aligne}, 8'd0);
    cyc();
    chk("repose_etat", {5'd0, etat}, 8'd2);
    cyc();
    chk("rechute_etat", {5'd0, etat}, 8'd1);

    for (int k = 0; k < 3; k++) effacer("clear_loop");
`ifdef CONTROLEUR_ACCELERATION_EN
    per = 7;
    chk("niveau_apres4", {5'd0, niveau}, 8'd1);
`else
    per = 8;
    chk("niveau_apres4", {5'd0, niveau}, 8'd0);
`endif
    for (int k = 1; k <= per; k++) tick_chk("periode_apres4", k == per);

`ifdef CONTROLEUR_ACCELERATION_EN
    for (int k = 0; k < 24; k++) effacer("clear_sat");
    chk("niveau_sature", {5'd0, niveau}, 8'd7);
    effacer("clear_sat_plus");
    chk("niveau_reste7", {5'd0, niveau}, 8'd7);
    for (int k = 0; k < 3; k++) tick_chk("periode1", 1'b1);
`endif

    hauteurC = 3'd7;
    plusC = 1'b1;
    cyc();
    plusC = 1'b0;
    chk("perdu_pose", {5'd0, etat}, 8'd2);
    cyc();
    chk("perdu_etat", {5'd0, etat}, 8'd5);
    chk("perdu_flag", {7'd0, perdu}, 8'd1);
    hauteurC = 3'd0;
    for (int k = 0; k < 6; k++) begin
      enable = k[0]; plusG = 1'b1; plusD = k[1]; tombeeBrique = 1'b1;
      cyc();
      chk("perdu_pulses", {5'd0, tickChute, moins, aligne}, 8'd0);
      chk("perdu_absorb", {4'd0, perdu, etat}, 8'h0d);
    end
    plusG = 1'b0; plusD = 1'b0; tombeeBrique = 1'b0; enable = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("perdu_rst_etat", {5'd0, etat}, 8'd0);
    chk("perdu_rst_flag", {7'd0, perdu}, 8'd0);
    chk("perdu_rst_niveau", {5'd0, niveau}, 8'd0);

    cyc();
    chk("rst2_chute", {5'd0, etat}, 8'd1);
    hauteurG = 3'd1; hauteurC = 3'd1; hauteurD = 3'd1;
    plusG = 1'b1;
    cyc();
    plusG = 1'b0;
    cyc();
    chk("mid_eff_moins", {6'd0, moins, aligne}, 8'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_eff_rst_pulses", {6'd0, moins, aligne}, 8'd0);
    chk("mid_eff_rst_etat", {5'd0, etat}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
